// File: rtl/uart_tx_param.sv
// uart_tx_param
//
// UART transmitter with a built-in transmit FIFO and baud-rate divider.
// Bytes pushed through wr_en/wr_data are queued and serialised LSB-first
// on txd as: start bit, 5..8 data bits, optional parity bit, 1 or 2 stop
// bits. Each bit lasts baud_div+1 clock cycles. The frame format and the
// divisor are sampled when a byte leaves the FIFO, so they can be changed
// at any time without corrupting the frame on the wire.
//
// Ports
//   clk         system clock
//   rstb        asynchronous active-low reset
//   wr_en       push wr_data into the FIFO this cycle
//   wr_data     byte to transmit
//   baud_div    bit period minus one, in clk cycles
//   data_len    00=5, 01=6, 10=7, 11=8 data bits
//   parity_en   append a parity bit
//   parity_odd  1=odd parity, 0=even parity
//   stop2       1=two stop bits, 0=one stop bit
//   break_en    hold the line low while idle and hold off new frames
//   txd         registered serial output, idles high
//   busy        a frame is on the wire
//   tx_done     one-cycle pulse in the last cycle of the final stop bit
//   full        FIFO full
//   empty       FIFO empty
//   level       FIFO occupancy
//   ovf         one-cycle pulse after a write was dropped because of full

module uart_tx_param #(
  parameter int DEPTH = 16,
  parameter int DIVW  = 16
) (
  input  logic                     clk,
  input  logic                     rstb,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic [DIVW-1:0]          baud_div,
  input  logic [1:0]               data_len,
  input  logic                     parity_en,
  input  logic                     parity_odd,
  input  logic                     stop2,
  input  logic                     break_en,
  output logic                     txd,
  output logic                     busy,
  output logic                     tx_done,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  // Parity over the active data bits only; bits above the frame length
  // are masked off before the reduction.
  function automatic logic calc_parity(input logic [7:0] d,
                                       input logic [1:0] len,
                                       input logic       odd);
    logic [7:0] mask;
    mask = 8'hFF >> (3'd3 - {1'b0, len});
    return (^(d & mask)) ^ odd;
  endfunction

  // ---------------------------------------------------------------------
  // Transmit FIFO
  // ---------------------------------------------------------------------
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;

  // A write while full is dropped even if a pop frees a slot this cycle.
  assign push  = wr_en && !full;
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign level = count;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      ovf <= wr_en && full;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Frame registers, loaded at pop time
  // ---------------------------------------------------------------------
  logic [7:0]      data_f;
  logic [DIVW-1:0] div_f;
  logic [1:0]      len_f;
  logic            pe_f;
  logic            po_f;
  logic            s2_f;

  always_ff @(posedge clk) begin
    if (pop) begin
      data_f <= mem[rd_ptr];
      div_f  <= baud_div;
      len_f  <= data_len;
      pe_f   <= parity_en;
      po_f   <= parity_odd;
      s2_f   <= stop2;
    end
  end

  // ---------------------------------------------------------------------
  // Serialiser FSM
  // ---------------------------------------------------------------------
  state_t          state_q;
  state_t          state_d;
  logic [DIVW-1:0] timer_q;
  logic [DIVW-1:0] timer_d;
  logic [2:0]      bit_q;
  logic [2:0]      bit_d;
  logic            stop_q;
  logic            stop_d;
  logic            txd_d;
  logic            done;
  logic            bit_end;
  logic [2:0]      last_bit;

  assign bit_end  = (timer_q == div_f);
  // Index of the final data bit: data_len + 4 (5..8 bits).
  assign last_bit = {1'b1, len_f};

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      txd     <= 1'b1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      txd     <= txd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    pop     = 1'b0;
    done    = 1'b0;

    case (state_q)
      IDLE: begin
        if (!empty && !break_en) begin
          pop     = 1'b1;
          state_d = START;
          timer_d = '0;
        end
      end

      START: begin
        if (bit_end) begin
          state_d = DATA;
          timer_d = '0;
          bit_d   = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      DATA: begin
        if (bit_end) begin
          timer_d = '0;
          if (bit_q == last_bit) begin
            stop_d  = 1'b0;
            state_d = pe_f ? PARITY : STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      PARITY: begin
        if (bit_end) begin
          timer_d = '0;
          stop_d  = 1'b0;
          state_d = STOP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      STOP: begin
        if (bit_end) begin
          timer_d = '0;
          if (s2_f && !stop_q) begin
            stop_d = 1'b1;
          end else begin
            done = 1'b1;
            // Chain straight into the next start bit when data is waiting.
            if (!empty && !break_en) begin
              pop     = 1'b1;
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  // txd is registered, so its next value follows the next state. On entry
  // to START the frame registers are still being loaded, but START drives
  // a constant so that does not matter.
  always_comb begin
    txd_d = 1'b1;
    case (state_d)
      IDLE:    txd_d = ~break_en;
      START:   txd_d = 1'b0;
      DATA:    txd_d = data_f[bit_d];
      PARITY:  txd_d = calc_parity(data_f, len_f, po_f);
      STOP:    txd_d = 1'b1;
      default: txd_d = 1'b1;
    endcase
  end

  assign busy    = (state_q != IDLE);
  assign tx_done = done;

endmodule
